// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a single-port synchronous SRAM with registered read data.
// Writes complete with zero wait states; reads stall for 1+WAIT_STATES cycles.
module ahb_sram_slave #(
    parameter int unsigned MEM_BYTES   = 2**26,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_ben,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
        S_READ_LAST = 3'd3,
        S_ERR1      = 3'd4,
        S_ERR2      = 3'd5
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t      state_q, state_d, out_state;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        accept;
    logic        addr_err;
    logic [3:0]  wr_ben;
    logic        unused_htrans0;

    // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
    assign unused_htrans0 = HTRANS[0];

    assign accept = HSEL & HTRANS[1] & HREADY & HREADYOUT;

    always_comb begin
        addr_err = (HADDR >= MEM_BYTES);
        case (HSIZE)
            3'd0:    ;
            3'd1:    if (HADDR[0]) addr_err = 1'b1;
            3'd2:    if (HADDR[1:0] != 2'b00) addr_err = 1'b1;
            default: addr_err = 1'b1;
        endcase
    end

    always_comb begin
        wr_ben = 4'b0000;
        case (size_q)
            3'd0:    wr_ben = ~(4'b0001 << addr_q[1:0]);
            3'd1:    wr_ben = addr_q[1] ? 4'b0011 : 4'b1100;
            default: wr_ben = 4'b0000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_READ: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_READ_LAST;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        // Only states that drive HREADYOUT high can reach here with accept set.
        if (accept) begin
            addr_d     = HADDR;
            write_d    = HWRITE;
            size_d     = HSIZE;
            wait_cnt_d = 4'd0;
            if (addr_err)    state_d = S_ERR1;
            else if (HWRITE) state_d = S_WRITE;
            else             state_d = S_READ;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Reset masks the SRAM strobes in the reset cycle so an abandoned access never reaches the array.
    assign out_state = HRESET ? S_IDLE : state_q;

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = 4'b1111;
        sram_addr = 32'h0;
        sram_din  = 32'h0;
        case (out_state)
            S_WRITE: begin
                sram_cen  = 1'b0;
                sram_wen  = ~write_q;
                sram_ben  = wr_ben;
                sram_addr = {addr_q[31:2], 2'b00};
                sram_din  = HWDATA;
            end
            S_READ: begin
                HREADYOUT = 1'b0;
                sram_cen  = 1'b0;
                sram_wen  = ~write_q;
                sram_ben  = 4'b0000;
                sram_addr = {addr_q[31:2], 2'b00};
            end
            S_READ_LAST: HRDATA = sram_dout;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
    end

endmodule
